// File: rtl/mem_loader.sv
`default_nettype none
//============================================================================
// Module      : mem_loader
// Description : Host-side byte-stream loader in front of port B of the
//               dual-port data RAM. Decodes a three-byte header
//               (command, start address, count) and then either streams
//               payload bytes into the RAM (write burst) or streams RAM
//               contents back out (read burst). cpu_hold stays high for
//               the whole command so the processor leaves port A idle.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      synchronous active-low reset
//     in_data    command / address / count / payload byte
//     in_valid   in_data valid
//     in_ready   loader accepts in_data this cycle
//     out_data   read-burst byte (registered)
//     out_valid  out_data valid (registered)
//     out_ready  consumer accepts out_data
//     addr_b     RAM port B address
//     din_b      RAM port B write data
//     we_b       RAM port B write enable
//     dout_b     RAM port B read data (combinational read of addr_b)
//     cpu_hold   high whenever a command is in progress
//     done       one-cycle pulse when a burst completes
//     err        one-cycle pulse on an unrecognised command byte
//
// Revision    : 1.0 - initial release
//============================================================================
module mem_loader #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_WR     = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] CMD_RD     = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] din_b,
    output logic                  we_b,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    // Count register is one bit wider than the address so that a full
    // 2**ADDR_WIDTH burst (encoded as a count byte of zero) is representable.
    localparam int                c_CNT_W    = ADDR_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_CNT  = 3'd2,
        S_WRITE    = 3'd3,
        S_READ     = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_op_rd;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [c_CNT_W-1:0]      r_remaining;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic                    r_done;
    logic                    r_err;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_is_cmd;
    logic                    w_rd_load;
    logic                    w_rd_consume;
    logic                    w_rd_last;
    logic                    w_wr_last;
    logic [ADDR_WIDTH-1:0]   w_in_addr;

    // in_ready is gated by rst_n directly so no byte (and no RAM write) can
    // be taken during a reset cycle, even while the state is still WRITE.
    assign w_in_ready   = rst_n && (r_state != S_READ);
    assign w_accept     = in_valid && w_in_ready;
    assign w_is_cmd     = (in_data == CMD_WR) || (in_data == CMD_RD);
    assign w_in_addr    = in_data[ADDR_WIDTH-1:0];

    // Output register refills when empty or being drained this cycle, so a
    // non-stalling consumer sees one byte per cycle.
    assign w_rd_consume = r_out_valid && out_ready;
    assign w_rd_load    = (r_state == S_READ) && (r_remaining != '0) &&
                          (!r_out_valid || out_ready);
    assign w_rd_last    = (r_state == S_READ) && w_rd_consume && (r_remaining == '0);
    assign w_wr_last    = (r_state == S_WRITE) && w_accept &&
                          (r_remaining <= c_CNT_W'(1));

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //------------------------------------------------------------------------
    // Next-state and combinational outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = w_in_ready;
        we_b         = 1'b0;
        din_b        = '0;
        cpu_hold     = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_cmd) begin
                    w_next_state = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (w_accept) begin
                    w_next_state = S_GET_CNT;
                end
            end
            S_GET_CNT: begin
                if (w_accept) begin
                    w_next_state = r_op_rd ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                we_b  = w_accept;
                din_b = in_data;
                if (w_wr_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ: begin
                if (w_rd_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Datapath: opcode, address pointer, remaining count, output register,
    // status pulses
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_rd     <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_cmd) begin
                            r_op_rd <= (in_data == CMD_RD);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (w_accept) begin
                        r_addr <= w_in_addr;
                    end
                end
                S_GET_CNT: begin
                    if (w_accept) begin
                        r_remaining <= (w_in_addr == '0) ? c_FULL_CNT
                                                         : {1'b0, w_in_addr};
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - c_CNT_W'(1);
                    end
                    if (w_wr_last) begin
                        r_done <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_rd_load) begin
                        r_out_data  <= dout_b;
                        r_out_valid <= 1'b1;
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - c_CNT_W'(1);
                    end else if (w_rd_consume) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_rd_last) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign addr_b    = r_addr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_loader
// Description : Scoreboard testbench for mem_loader. Stimulus pushes the
//               expected RAM writes and read-burst bytes into queues; a
//               monitor on the falling edge pops and compares whenever the
//               DUT writes the RAM or hands over an output byte. A simple
//               256x8 RAM model with combinational read sits on port B.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] addr_b;
    logic [7:0] din_b;
    logic       we_b;
    logic [7:0] dout_b;
    logic       cpu_hold;
    logic       done;
    logic       err;

    mem_loader #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .CMD_WR     (8'hA5),
        .CMD_RD     (8'h5A)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addr_b    (addr_b),
        .din_b     (din_b),
        .we_b      (we_b),
        .dout_b    (dout_b),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model on port B
    logic [7:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    end
    always @(posedge clk) begin
        if (we_b) ram[addr_b] <= din_b;
    end
    assign dout_b = ram[addr_b];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq [$];
    logic [7:0] rq [$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int we_cnt   = 0;
    int rd_cnt   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    //------------------------------------------------------------------------
    // Monitor / scoreboard
    //------------------------------------------------------------------------
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data    = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (we_b) begin
                we_cnt++;
                if (wq.size() == 0) begin
                    chk("wr_unexpected", we_b, 1'b0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", addr_b, e.a);
                    chk("wr_data", din_b, e.d);
                end
            end
            if (hold_pending) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, hold_data);
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            if (out_valid && out_ready) begin
                rd_cnt++;
                if (rq.size() == 0) begin
                    chk("rd_unexpected", out_valid, 1'b0);
                end else begin
                    chk("rd_data", out_data, rq.pop_front());
                end
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (done || err) chk("done_err_excl", done & err, 1'b0);
        end
    end

    //------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    //------------------------------------------------------------------------
    task automatic send(input logic [7:0] b);
        int   n;
        logic rdy;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("send_timeout", rdy, 1'b1);
    endtask

    // Waits for the done pulse; optionally toggles out_ready 1,0,0,1 and
    // verifies in_ready stays low while a read is in progress.
    task automatic wait_done(input logic bp, input logic rd, output int cycles);
        logic [3:0] pat;
        logic       seen;
        logic       rdy_bad;
        pat      = 4'b1001;
        in_valid = 1'b0;
        seen     = 1'b0;
        rdy_bad  = 1'b0;
        cycles   = 0;
        while (!seen && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (rd && cpu_hold && in_ready) rdy_bad = 1'b1;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (bp) out_ready = pat[3 - (cycles % 4)];
            end
        end
        chk("done_seen", seen, 1'b1);
        if (rd) chk("rd_in_ready_low", rdy_bad, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    //------------------------------------------------------------------------
    // Directed tests
    //------------------------------------------------------------------------
    initial begin
        int cyc;
        int d0;
        int w0;
        int r0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_we_b", we_b, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cpu_hold", cpu_hold, 1'b0);
        chk("rst_addr_b", addr_b, 8'h00);
        chk("rst_din_b", din_b, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;

        // Write burst 0x10..0x12
        push_wr(8'h10, 8'h11);
        push_wr(8'h11, 8'h22);
        push_wr(8'h12, 8'h33);
        d0 = done_cnt;
        send(8'hA5);
        chk("wr_hold_after_cmd", cpu_hold, 1'b1);
        send(8'h10);
        send(8'h03);
        send(8'h11);
        chk("wr_hold_mid", cpu_hold, 1'b1);
        send(8'h22);
        send(8'h33);
        chk("wr_hold_end", cpu_hold, 1'b0);
        chk("wr_done_pulse", done, 1'b1);
        wait_done(1'b0, 1'b0, cyc);
        chk("wr_done_count", done_cnt - d0, 1);
        chk("wr_queue_empty", wq.size(), 0);

        // Readback with out_ready held high
        rq.push_back(8'h11);
        rq.push_back(8'h22);
        rq.push_back(8'h33);
        d0 = done_cnt;
        r0 = rd_cnt;
        send(8'h5A);
        send(8'h10);
        send(8'h03);
        wait_done(1'b0, 1'b1, cyc);
        chk("rd_latency", cyc, 5);
        chk("rd_count", rd_cnt - r0, 3);
        chk("rd_done_count", done_cnt - d0, 1);
        chk("rd_queue_empty", rq.size(), 0);

        // Address wrap
        push_wr(8'hFE, 8'hAA);
        push_wr(8'hFF, 8'hBB);
        push_wr(8'h00, 8'hCC);
        send(8'hA5);
        send(8'hFE);
        send(8'h03);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        wait_done(1'b0, 1'b0, cyc);
        chk("wrap_ram_ff", ram[255], 8'hBB);
        chk("wrap_ram_00", ram[0], 8'hCC);

        // Backpressured read across the wrap point
        rq.push_back(8'hAA);
        rq.push_back(8'hBB);
        rq.push_back(8'hCC);
        rq.push_back(8'h00);
        r0 = rd_cnt;
        send(8'h5A);
        send(8'hFE);
        send(8'h04);
        wait_done(1'b1, 1'b1, cyc);
        chk("bp_count", rd_cnt - r0, 4);
        chk("bp_queue_empty", rq.size(), 0);

        // Bad command, then a normal command
        d0 = err_cnt;
        send(8'h3C);
        chk("bad_err_pulse", err, 1'b1);
        chk("bad_done_low", done, 1'b0);
        chk("bad_cpu_hold", cpu_hold, 1'b0);
        chk("bad_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bad_err_clear", err, 1'b0);
        chk("bad_err_count", err_cnt - d0, 1);
        push_wr(8'h20, 8'h77);
        send(8'hA5);
        chk("after_bad_hold", cpu_hold, 1'b1);
        send(8'h20);
        send(8'h01);
        send(8'h77);
        wait_done(1'b0, 1'b0, cyc);
        chk("after_bad_ram", ram[32], 8'h77);

        // Full 256-byte burst (count byte 0)
        w0 = we_cnt;
        for (int i = 0; i < 256; i++) push_wr(8'(i), 8'(i) ^ 8'h5C);
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5C);
        wait_done(1'b0, 1'b0, cyc);
        chk("full_we_count", we_cnt - w0, 256);
        chk("full_queue_empty", wq.size(), 0);
        chk("full_ram_42", ram[66], 8'h1E);

        // Reset in the middle of a 5-byte write
        push_wr(8'h40, 8'hD1);
        push_wr(8'h41, 8'hD2);
        send(8'hA5);
        send(8'h40);
        send(8'h05);
        send(8'hD1);
        send(8'hD2);
        in_data  = 8'hD3;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_we_b", we_b, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_cpu_hold", cpu_hold, 1'b0);
        chk("mid_rst_addr_b", addr_b, 8'h00);
        chk("mid_rst_din_b", din_b, 8'h00);
        chk("mid_rst_done", done, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ram_40", ram[64], 8'hD1);
        chk("mid_rst_ram_41", ram[65], 8'hD2);
        chk("mid_rst_ram_42", ram[66], 8'h1E);
        push_wr(8'h40, 8'hE7);
        send(8'hA5);
        send(8'h40);
        send(8'h01);
        send(8'hE7);
        wait_done(1'b0, 1'b0, cyc);
        chk("fresh_ram_40", ram[64], 8'hE7);

        chk("total_done", done_cnt, 7);
        chk("total_err", err_cnt, 1);
        chk("final_wq_empty", wq.size(), 0);
        chk("final_rq_empty", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
